// File: rtl/seq_div_unit.sv
// -----------------------------------------------------------------------------
// seq_div_unit
//   Multi-cycle RV32M-style integer divider (div/divu/rem/remu). Restoring
//   radix-2: one quotient bit per clock. Sits beside the EX-stage ALU; the
//   pipeline stalls while busy_o is high and captures res_o on done_o.
//
// Ports
//   clk      in   rising-edge clock
//   rst      in   asynchronous, active-high reset
//   start_i  in   request, only sampled while idle
//   a_i      in   dividend (latched at start)
//   b_i      in   divisor  (latched at start)
//   op_i     in   00=div 01=divu 10=rem 11=remu (latched at start)
//   busy_o   out  operation in progress
//   ready_o  out  ~busy_o
//   done_o   out  one-cycle pulse, res_o valid
//   res_o    out  result, held until the next done_o
//
// Build option
//   DIV_BYPASS_EN : divide-by-zero and signed overflow skip the iteration
//                   loop and finish one edge after start. Results are the
//                   same with or without it; only latency changes.
// -----------------------------------------------------------------------------
module seq_div_unit #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start_i,
  input  logic [DATA_WIDTH-1:0] a_i,
  input  logic [DATA_WIDTH-1:0] b_i,
  input  logic [1:0]            op_i,
  output logic                  busy_o,
  output logic                  ready_o,
  output logic                  done_o,
  output logic [DATA_WIDTH-1:0] res_o
);

  localparam int W  = DATA_WIDTH;
  localparam int CW = $clog2(DATA_WIDTH) + 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_FIX  = 2'd2
  } state_t;

  state_t         state_q, state_d;
  logic [W-1:0]   quot_q, quot_d;   // dividend shifts out, quotient shifts in
  logic [W-1:0]   rem_q,  rem_d;    // partial remainder, always < divisor
  logic [W-1:0]   dvs_q,  dvs_d;    // divisor magnitude
  logic [CW-1:0]  cnt_q,  cnt_d;
  logic [1:0]     op_q,   op_d;
  logic           negq_q, negq_d;   // negate quotient in FIX
  logic           negr_q, negr_d;   // negate remainder in FIX
  logic           busy_q, busy_d;
  logic           done_q, done_d;
  logic [W-1:0]   res_q,  res_d;

  // Operand magnitudes. Taken in W+1 bits so |most-negative| is exact;
  // the top bit is always zero afterwards and only the low W bits are kept.
  logic         signed_op;
  logic [W:0]   a_ext, b_ext, a_abs, b_abs;
  logic [W-1:0] a_mag, b_mag;
  logic         b_zero;
  logic         unused_abs_msb;

  // One iteration step. The subtractor is W+1 bits; since rem < divisor,
  // the shifted value is < 2*divisor, so diff[W] is exactly the borrow.
  logic [W:0]   shifted, diff;
  logic         ge;

  logic [W-1:0] q_fix, r_fix;

`ifdef DIV_BYPASS_EN
  logic [W-1:0] most_neg;
  logic         ovf;
`endif

  always_comb begin
    signed_op      = ~op_i[0];
    a_ext          = {a_i[W-1] & signed_op, a_i};
    b_ext          = {b_i[W-1] & signed_op, b_i};
    a_abs          = a_ext[W] ? (~a_ext + 1'b1) : a_ext;
    b_abs          = b_ext[W] ? (~b_ext + 1'b1) : b_ext;
    a_mag          = a_abs[W-1:0];
    b_mag          = b_abs[W-1:0];
    b_zero         = (b_i == '0);
    unused_abs_msb = a_abs[W] ^ b_abs[W];

    shifted = {rem_q, quot_q[W-1]};
    diff    = shifted - {1'b0, dvs_q};
    ge      = ~diff[W];

    q_fix = negq_q ? (~quot_q + 1'b1) : quot_q;
    r_fix = negr_q ? (~rem_q  + 1'b1) : rem_q;

`ifdef DIV_BYPASS_EN
    most_neg = {1'b1, {(W-1){1'b0}}};
    ovf      = signed_op && (a_i == most_neg) && (b_i == '1);
`endif

    state_d = state_q;
    quot_d  = quot_q;
    rem_d   = rem_q;
    dvs_d   = dvs_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    negq_d  = negq_q;
    negr_d  = negr_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    res_d   = res_q;

    unique case (state_q)
      S_IDLE: begin
        if (start_i) begin
          quot_d  = a_mag;
          dvs_d   = b_mag;
          rem_d   = '0;
          cnt_d   = CW'(W);
          op_d    = op_i;
          // Quotient sign fix is suppressed on /0 so div keeps all ones.
          // Remainder sign fix on /0 turns |a| back into the original a.
          negq_d  = signed_op & (a_i[W-1] ^ b_i[W-1]) & ~b_zero;
          negr_d  = signed_op & a_i[W-1];
          busy_d  = 1'b1;
          state_d = S_CALC;
`ifdef DIV_BYPASS_EN
          // Preload what the loop would have produced and go straight to FIX.
          if (b_zero) begin
            quot_d  = '1;
            rem_d   = a_mag;
            state_d = S_FIX;
          end else if (ovf) begin
            quot_d  = a_mag;
            rem_d   = '0;
            state_d = S_FIX;
          end
`endif
        end
      end

      S_CALC: begin
        rem_d  = ge ? diff[W-1:0] : shifted[W-1:0];
        quot_d = {quot_q[W-2:0], ge};
        cnt_d  = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) state_d = S_FIX;
      end

      S_FIX: begin
        res_d   = op_q[1] ? r_fix : q_fix;
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end

      default: begin
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      quot_q  <= '0;
      rem_q   <= '0;
      dvs_q   <= '0;
      cnt_q   <= '0;
      op_q    <= '0;
      negq_q  <= 1'b0;
      negr_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      res_q   <= '0;
    end else begin
      state_q <= state_d;
      quot_q  <= quot_d;
      rem_q   <= rem_d;
      dvs_q   <= dvs_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      negq_q  <= negq_d;
      negr_q  <= negr_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      res_q   <= res_d;
    end
  end

  assign busy_o  = busy_q;
  assign ready_o = ~busy_q;
  assign done_o  = done_q;
  assign res_o   = res_q;

endmodule

// File: doc/seq_div_unit.md
Name: seq_div_unit

Overview:
- Multi-cycle integer divider implementing the RV32M div/divu/rem/remu group, which the single-cycle ALU does not support.
- Sits beside the ALU in EX. The control path stalls the pipeline while busy_o=1 and captures res_o on done_o.
- Generalised: parametrised width, start/done handshake, restoring radix-2 algorithm (one quotient bit per cycle).
- Full RISC-V divide-by-zero and signed-overflow semantics.

Parameters:
- DATA_WIDTH, 32, operand/result width (>=4). Iteration counter width is $clog2(DATA_WIDTH)+1.

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-high reset
- start_i  in  1  request; sampled only in IDLE
- a_i  in  DATA_WIDTH  dividend; latched at start
- b_i  in  DATA_WIDTH  divisor; latched at start
- op_i  in  2  00=div, 01=divu, 10=rem, 11=remu; latched at start
- busy_o  out  1  operation in progress
- ready_o  out  1  ~busy_o
- done_o  out  1  one-cycle pulse, res_o valid
- res_o  out  DATA_WIDTH  result; held until next done_o

Behaviour:
- Clock and reset: one clock (clk). rst is asynchronous and active-high.
- Reset values: state=IDLE, busy_o=0, done_o=0, res_o=0, internal registers cleared.
- Reset mid-operation: aborts immediately. No done_o is produced for the aborted op.

States:
- IDLE: if start_i, latch operands and op. Signed ops (div, rem) store |a|, |b|, neg_q=a[MSB]^b[MSB], neg_r=a[MSB]. Unsigned ops store raw values. Clear the partial remainder and load count=DATA_WIDTH. Go to CALC.
- CALC: each cycle, shift {rem,quot} left by 1 with the dividend MSB entering rem. If rem>=divisor, subtract the divisor and set the quotient LSB to 1. Decrement count. When count reaches 1 on the current edge, go to FIX.
- FIX: apply sign correction. div: quotient negated if neg_q. rem: remainder negated if neg_r. Load res_o, pulse done_o, go to IDLE.

Timing:
- start sampled at edge E0. Iterations occur on E1..E(DATA_WIDTH). res_o and done_o update on E(DATA_WIDTH+1).
- Latency is DATA_WIDTH+1 edges (33 for 32-bit).
- busy_o=1 from E0 until E(DATA_WIDTH+1). It falls on the same edge done_o rises.
- start_i while busy_o=1 is ignored; there is no queueing.
- start_i in the cycle done_o=1 is accepted, because the state is IDLE, giving back-to-back operation.

Arithmetic and width rules:
- abs(most-negative) is taken in DATA_WIDTH+1 bits, so it is correct.
- The subtractor is DATA_WIDTH+1 bits wide.

Boundary results:
- Divide by zero, natural algorithm result: quotient = all ones for both div and divu, remainder = dividend.
  - The signed div quotient must still be all ones. Sign correction is suppressed when b==0.
  - Signed rem by zero returns the original a (not |a|).
- Signed overflow, a=most-negative and b=-1 with div: quotient = most-negative, remainder = 0. This falls out of the algorithm plus width rule; verify explicitly.

Optional Feature:
- Macro: DIV_BYPASS_EN.
- Defined: in IDLE, b==0, or signed overflow (div/rem with a=most-negative and b=all ones), skips CALC. State goes IDLE to FIX with the final result precomputed. res_o and done_o update on E1, so latency is 1 edge and busy_o is high for one cycle.
- Not defined: every operation takes DATA_WIDTH+1 edges. Results are identical in both builds; only latency differs.

Test Plan:
- divu a=100, b=7: res_o=14, done_o pulses exactly 33 edges after start. remu, same operands: res_o=2.
- div a=-7 (0xFFFFFFF9), b=2: res_o=0xFFFFFFFD. rem, same operands: res_o=0xFFFFFFFF. div a=7, b=-2: res_o=0xFFFFFFFD.
- Divide by zero:
  - div 5/0: res_o=0xFFFFFFFF.
  - divu 5/0: res_o=0xFFFFFFFF.
  - rem 0xFFFFFFF9/0: res_o=0xFFFFFFF9.
  - remu 5/0: res_o=5.
  - Latency 33 without DIV_BYPASS_EN, 1 with it.
- Overflow, a=0x80000000, b=0xFFFFFFFF: div gives res_o=0x80000000, rem gives res_o=0. Also divu with the same operands gives res_o=0, no overflow special case.
- start_i held high during a divu 100/7 with a_i changed mid-operation: result is still 14 and only one done_o appears. A new start in the done_o cycle is accepted, giving a second done_o 33 edges later.
- rst asserted asynchronously at iteration 10: busy_o, done_o and res_o go to 0 immediately. After release, divu 9/3 returns 3 with normal latency.
